tm_controller: RTL and testbench

//  Finite-state control unit for the lab3 Turing machine. It drives the 7-cell tape's head/write_ena/write_data and consumes its read_data.
//  It executes a programmable rule table: (tm_state, symbol) -> (write symbol, move, next state | halt).

---
 rtl/tm_pkg.sv | 36 +++
 rtl/tm_controller_if.sv | 22 ++
 rtl/tm_rule_table.sv | 24 ++
 rtl/tm_controller.sv | 124 ++++++++++++
 tb/tb_tm_controller.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tm_pkg.sv
// rtl/tm_pkg.sv - shared encodings, rule field positions and widths for the Turing machine controller
package tm_pkg;

    localparam int SYM_W   = 2;
    localparam int STATE_W = 2;
    localparam int HEAD_W  = 3;
    localparam int RULE_W  = 6;
    localparam int ADDR_W  = STATE_W + SYM_W;

    localparam int HALT_BIT = 5;
    localparam int DIR_BIT  = 4;
    localparam int WSYM_HI  = 3;
    localparam int WSYM_LO  = 2;
    localparam int NEXT_HI  = 1;
    localparam int NEXT_LO  = 0;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [RULE_W-1:0] RULE_HALT = 6'b100000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_MOVE  = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } fsm_t;

    function automatic logic [ADDR_W-1:0] rule_addr(input logic [STATE_W-1:0] st,
                                                   input logic [SYM_W-1:0] sym);
        return {st, sym};
    endfunction

endpackage

// File: rtl/tm_controller_if.sv
// rtl/tm_controller_if.sv - tape access and rule-programming bus of the Turing machine controller
interface tm_controller_if
    import tm_pkg::*;
();
    logic [HEAD_W-1:0] head;
    logic              write_ena;
    logic [SYM_W-1:0]  write_data;
    logic [SYM_W-1:0]  read_data;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [RULE_W-1:0] prog_data;

    modport master (
        output head, write_ena, write_data,
        input  read_data, prog_we, prog_addr, prog_data
    );

    modport slave (
        input  head, write_ena, write_data,
        output read_data, prog_we, prog_addr, prog_data
    );
endinterface

// File: rtl/tm_rule_table.sv
// rtl/tm_rule_table.sv - 16x6 rule register file, sync write, async read, resets to all-halt
module tm_rule_table
    import tm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [RULE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [RULE_W-1:0] rdata
);
    logic [RULE_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= RULE_HALT;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/tm_controller.sv
// rtl/tm_controller.sv - Turing machine step FSM driving a 7-cell tape; optional step limit via TM_STEP_LIMIT_EN
module tm_controller
    import tm_pkg::*;
#(
    parameter int unsigned TAPE_LEN   = 7,
    parameter int unsigned START_HEAD = 0,
    parameter int unsigned MAX_STEPS  = 255
) (
    input  logic               clk,
    input  logic               rst,
    tm_controller_if.master    bus,
    input  logic               start,
    output logic [STATE_W-1:0] tm_state,
    output logic               busy,
    output logic               halted,
`ifdef TM_STEP_LIMIT_EN
    output logic               fault,
    output logic [7:0]         step_count
`else
    output logic               fault
`endif
);
    localparam logic [HEAD_W-1:0] HEAD_START = HEAD_W'(START_HEAD);
    localparam logic [HEAD_W-1:0] HEAD_LAST  = HEAD_W'(TAPE_LEN - 1);

    fsm_t               state_q, state_d;
    logic [HEAD_W-1:0]  head_q, head_d;
    logic [STATE_W-1:0] tm_q, tm_d;
    logic [RULE_W-1:0]  rule_q, rule_d;
    logic [RULE_W-1:0]  table_rdata;
    logic               table_we;

    assign table_we = bus.prog_we && !busy;

    tm_rule_table u_rule_table (
        .clk   (clk),
        .rst   (rst),
        .we    (table_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (rule_addr(tm_q, bus.read_data)),
        .rdata (table_rdata)
    );

`ifdef TM_STEP_LIMIT_EN
    logic [7:0] cnt_q, cnt_d, cnt_inc;
    assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign step_count = cnt_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            head_q  <= HEAD_START;
            tm_q    <= '0;
            rule_q  <= RULE_HALT;
`ifdef TM_STEP_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tm_q    <= tm_d;
            rule_q  <= rule_d;
`ifdef TM_STEP_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tm_d    = tm_q;
        rule_d  = rule_q;
`ifdef TM_STEP_LIMIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_FAULT: begin
                if (start) begin
                    head_d  = HEAD_START;
                    tm_d    = '0;
                    state_d = S_READ;
`ifdef TM_STEP_LIMIT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_READ:  begin
                rule_d  = table_rdata;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_MOVE;
            S_MOVE: begin
                if (rule_q[HALT_BIT]) begin
                    state_d = S_DONE;
                end else if ((rule_q[DIR_BIT] == DIR_LEFT && head_q == '0) ||
                             (rule_q[DIR_BIT] == DIR_RIGHT && head_q == HEAD_LAST)) begin
                    state_d = S_FAULT;
                end else begin
                    head_d  = (rule_q[DIR_BIT] == DIR_RIGHT) ? head_q + 3'd1 : head_q - 3'd1;
                    tm_d    = rule_q[NEXT_HI:NEXT_LO];
                    state_d = S_READ;
`ifdef TM_STEP_LIMIT_EN
                    cnt_d   = cnt_inc;
                    // The step that reaches the limit still moves, but the run stops there.
                    if (cnt_inc >= 8'(MAX_STEPS)) state_d = S_FAULT;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tape strobes decode straight from state so an async reset drops them without a clock edge.
    assign bus.write_ena  = (state_q == S_WRITE);
    assign bus.write_data = (state_q == S_WRITE) ? rule_q[WSYM_HI:WSYM_LO] : '0;
    assign bus.head       = head_q;
    assign tm_state       = tm_q;
    assign busy           = (state_q == S_READ) || (state_q == S_WRITE) || (state_q == S_MOVE);
    assign halted         = (state_q == S_DONE);
    assign fault          = (state_q == S_FAULT);
endmodule

// File: tb/tb_tm_controller.sv
// tb/tb_tm_controller.sv - directed testbench for tm_controller with a behavioural 7-cell tape
module tb_tm_controller;
    import tm_pkg::*;

`ifdef TM_STEP_LIMIT_EN
    localparam int unsigned MS = 4;
`else
    localparam int unsigned MS = 255;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] tm_state;
    logic       busy, halted, fault;
`ifdef TM_STEP_LIMIT_EN
    logic [7:0] step_count;
`endif

    tm_controller_if bus ();

    tm_controller #(.TAPE_LEN(7), .START_HEAD(0), .MAX_STEPS(MS)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
        .start      (start),
        .tm_state   (tm_state),
        .busy       (busy),
        .halted     (halted),
`ifdef TM_STEP_LIMIT_EN
        .fault      (fault),
        .step_count (step_count)
`else
        .fault      (fault)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       clr = 1'b0;
    logic [1:0] tape [7];
    logic [4:0] trace [32];
    int         ntrace = 0;

    assign bus.read_data = (bus.head < 3'd7) ? tape[bus.head] : 2'b00;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 7; i++) tape[i] <= 2'b00;
            ntrace <= 0;
        end else if (bus.write_ena) begin
            if (bus.head < 3'd7) tape[bus.head] <= bus.write_data;
            if (ntrace < 32) trace[ntrace] <= {bus.head, bus.write_data};
            ntrace <= ntrace + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        bus.prog_we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic clear_tape();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic prog_rule(input logic [3:0] addr, input logic [5:0] data);
        @(negedge clk);
        bus.prog_we = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        @(negedge clk);
        bus.prog_we = 1'b0;
    endtask

    task automatic start_run();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        bit seen;
        do_reset();
        checks++; if (bus.head !== 3'd0 || tm_state !== 2'd0 || bus.write_ena !== 1'b0 || bus.write_data !== 2'd0)
            begin errors++; $display("FAIL reset_outputs head=%0d tm_state=%0d we=%b wd=%0d required 0/0/0/0", bus.head, tm_state, bus.write_ena, bus.write_data); end
        checks++; if ({busy, halted, fault} !== 3'b000)
            begin errors++; $display("FAIL reset_status busy/halted/fault=%b required 000", {busy, halted, fault}); end
        for (int a = 0; a < 4; a++) prog_rule(4'(a), 6'b010100);
        clear_tape();
        start_run();
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (bus.write_ena === 1'b1 && bus.head == 3'd2) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL reset_wait write at head 2 not seen required seen"); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.write_ena !== 1'b0 || bus.head !== 3'd0 || {busy, halted, fault} !== 3'b000 || tm_state !== 2'd0)
            begin errors++; $display("FAIL async_reset we=%b head=%0d bhf=%b st=%0d required 0/0/000/0", bus.write_ena, bus.head, {busy, halted, fault}, tm_state); end
        @(negedge clk) rst = 1'b1;
        clear_tape();
        start_run();
        wait_cycles(3);
        checks++; if (halted !== 1'b1 || ntrace !== 1 || trace[0] !== 5'b000_00)
            begin errors++; $display("FAIL reset_table halted=%b writes=%0d first=%b required 1/1/00000", halted, ntrace, trace[0]); end
    endtask

    task automatic test_run_right();
        do_reset();
        for (int a = 0; a < 4; a++) prog_rule(4'(a), 6'b010100);
        clear_tape();
        start_run();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL right_busy busy=%b required 1", busy); end
        wait_cycles(20);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL right_early fault=%b at cycle 20 required 0", fault); end
        wait_cycles(1);
        checks++; if (fault !== 1'b1 || bus.head !== 3'd6 || busy !== 1'b0)
            begin errors++; $display("FAIL right_fault fault=%b head=%0d busy=%b required 1/6/0", fault, bus.head, busy); end
        checks++; if (ntrace !== 7) begin errors++; $display("FAIL right_count writes=%0d required 7", ntrace); end
        for (int i = 0; i < 7; i++) begin
            logic [4:0] exp;
            exp = {i[2:0], 2'b01};
            checks++; if (trace[i] !== exp || tape[i] !== 2'b01)
                begin errors++; $display("FAIL right_trace%0d write=%b cell=%b required %b/01", i, trace[i], tape[i], exp); end
        end
    endtask

    task automatic test_halt();
        do_reset();
        prog_rule(4'h0, 6'b101000);
        clear_tape();
        start_run();
        wait_cycles(2);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early halted=%b required 0", halted); end
        wait_cycles(1);
        checks++; if (halted !== 1'b1 || bus.head !== 3'd0 || ntrace !== 1 || trace[0] !== 5'b000_10)
            begin errors++; $display("FAIL halt_done halted=%b head=%0d writes=%0d first=%b required 1/0/1/00010", halted, bus.head, ntrace, trace[0]); end
        wait_cycles(6);
        checks++; if (halted !== 1'b1 || ntrace !== 1 || busy !== 1'b0)
            begin errors++; $display("FAIL halt_hold halted=%b writes=%0d busy=%b required 1/1/0", halted, ntrace, busy); end
    endtask

    task automatic test_run_left();
        do_reset();
        for (int a = 0; a < 4; a++) prog_rule(4'(a), 6'b001100);
        clear_tape();
        start_run();
        wait_cycles(3);
        checks++; if (fault !== 1'b1 || bus.head !== 3'd0 || ntrace !== 1 || trace[0] !== 5'b000_11)
            begin errors++; $display("FAIL left_fault fault=%b head=%0d writes=%0d first=%b required 1/0/1/00011", fault, bus.head, ntrace, trace[0]); end
        wait_cycles(10);
        checks++; if (ntrace !== 1 || fault !== 1'b1)
            begin errors++; $display("FAIL left_hold writes=%0d fault=%b required 1/1", ntrace, fault); end
    endtask

    task automatic test_two_state();
        do_reset();
        prog_rule(4'h0, 6'b010101);
        prog_rule(4'h4, 6'b011000);
        clear_tape();
        start_run();
        wait_cycles(3);
        checks++; if (tm_state !== 2'd1 || bus.head !== 3'd1)
            begin errors++; $display("FAIL two_state_step tm_state=%0d head=%0d required 1/1", tm_state, bus.head); end
        wait_cycles(18);
        checks++; if (fault !== 1'b1 || tm_state !== 2'd0 || bus.head !== 3'd6)
            begin errors++; $display("FAIL two_state_end fault=%b tm_state=%0d head=%0d required 1/0/6", fault, tm_state, bus.head); end
        for (int i = 0; i < 7; i++) begin
            logic [1:0] exp;
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (tape[i] !== exp)
                begin errors++; $display("FAIL two_state_cell%0d cell=%b required %b", i, tape[i], exp); end
        end
    endtask

    task automatic test_prog_lock();
        logic [4:0] first [7];
        bit done;
        do_reset();
        for (int a = 0; a < 4; a++) prog_rule(4'(a), 6'b011000);
        clear_tape();
        start_run();
        wait_cycles(4);
        bus.prog_we = 1'b1;
        bus.prog_addr = 4'h0;
        bus.prog_data = 6'b101100;
        @(negedge clk) bus.prog_we = 1'b0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (fault) done = 1;
        end
        checks++; if (!done || ntrace !== 7)
            begin errors++; $display("FAIL lock_run1 fault_seen=%0d writes=%0d required 1/7", done, ntrace); end
        for (int i = 0; i < 7; i++) first[i] = trace[i];
        clear_tape();
        start_run();
        wait_cycles(21);
        checks++; if (fault !== 1'b1 || ntrace !== 7)
            begin errors++; $display("FAIL lock_run2 fault=%b writes=%0d required 1/7", fault, ntrace); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (trace[i] !== first[i] || trace[i] !== {3'(i), 2'b10})
                begin errors++; $display("FAIL lock_trace%0d write=%b required %b", i, trace[i], {3'(i), 2'b10}); end
        end
        clear_tape();
        @(negedge clk);
        start = 1'b1;
        bus.prog_we = 1'b1;
        bus.prog_addr = 4'h0;
        bus.prog_data = 6'b101100;
        @(negedge clk);
        start = 1'b0;
        bus.prog_we = 1'b0;
        wait_cycles(3);
        checks++; if (halted !== 1'b1 || ntrace !== 1 || trace[0] !== 5'b000_11)
            begin errors++; $display("FAIL start_with_prog halted=%b writes=%0d first=%b required 1/1/00011", halted, ntrace, trace[0]); end
    endtask

`ifdef TM_STEP_LIMIT_EN
    task automatic test_step_limit();
        do_reset();
        for (int a = 0; a < 4; a++) prog_rule(4'(a), 6'b010001);
        for (int a = 4; a < 8; a++) prog_rule(4'(a), 6'b000000);
        clear_tape();
        start_run();
        checks++; if (step_count !== 8'd0) begin errors++; $display("FAIL limit_clear step_count=%0d required 0", step_count); end
        wait_cycles(11);
        checks++; if (fault !== 1'b0 || step_count !== 8'd3)
            begin errors++; $display("FAIL limit_early fault=%b step_count=%0d required 0/3", fault, step_count); end
        wait_cycles(1);
        checks++; if (fault !== 1'b1 || step_count !== 8'd4 || bus.head !== 3'd0)
            begin errors++; $display("FAIL limit_fault fault=%b step_count=%0d head=%0d required 1/4/0", fault, step_count, bus.head); end
    endtask
`endif

    initial begin
        bus.prog_we = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        for (int i = 0; i < 7; i++) tape[i] = 2'b00;
        test_reset();
        test_run_right();
        test_halt();
        test_run_left();
        test_two_state();
        test_prog_lock();
`ifdef TM_STEP_LIMIT_EN
        test_step_limit();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
